// File: rtl/raw_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// raw_fifo_wr_arbiter
//
// Frame-granular round-robin arbiter that shares the write port of the 9-bit
// raw frame FIFO ({end-of-frame, byte}) between two byte-stream sources.
// A new frame is admitted only while the FIFO is not almost-full, which
// guarantees room for a maximum-length frame. The granted source then owns
// the port until its last byte has been written.
//
// Optional build macro: RAW_FIFO_ARB_STATS_EN adds per-source completed-frame
// counters (frm_cnt0/frm_cnt1). Without it those ports do not exist and the
// arbitration behaviour is unchanged.
//
// Parameters
//   CNT_W       width of the per-source frame counters (stats build)
//   FIRST_PRIO  source (0/1) that wins the first contested arbitration
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s0_data/last/valid    source 0 byte stream;  s0_ready = byte accepted
//   s1_data/last/valid    source 1 byte stream;  s1_ready = byte accepted
//   fifo_di, fifo_we      FIFO write data {last, data} and write enable
//   fifo_full, fifo_afull FIFO full and almost-full flags
//   grant                 one-hot current owner, 2'b00 when idle
//   busy                  a frame transfer is in progress
//   frm_cnt0, frm_cnt1    completed frames per source (stats build only)
// ---------------------------------------------------------------------------
module raw_fifo_wr_arbiter #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned FIRST_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s0_data,
  input  logic             s0_last,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_last,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [8:0]       fifo_di,
  output logic             fifo_we,
  input  logic             fifo_full,
  input  logic             fifo_afull,
  output logic [1:0]       grant,
  output logic             busy
`ifdef RAW_FIFO_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] frm_cnt0,
  output logic [CNT_W-1:0] frm_cnt1
`endif
);

  // Elaboration-time sanity check of the configuration.
  if (CNT_W < 1 || FIRST_PRIO > 1) begin : g_param_check
    $error("raw_fifo_wr_arbiter: CNT_W must be >= 1 and FIRST_PRIO must be 0 or 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    XFER0 = 2'b01,
    XFER1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   rr_ptr_q, rr_ptr_d;   // source preferred at the next contested grant
  logic   last0_acc, last1_acc; // final beat of a frame written this cycle

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= (FIRST_PRIO != 0);
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Next-state and write-port steering. Outputs decode the registered state,
  // so reset forces them low immediately without waiting for a clock edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    fifo_we  = 1'b0;
    fifo_di  = '0;

    unique case (state_q)
      IDLE: begin
        // Arbitration cycle: nothing is accepted here. Admission requires
        // room for a whole frame; once granted, afull is no longer looked at.
        if (!fifo_afull) begin
          if (s0_valid && s1_valid) state_d = rr_ptr_q ? XFER1 : XFER0;
          else if (s0_valid)        state_d = XFER0;
          else if (s1_valid)        state_d = XFER1;
        end
      end
      XFER0: begin
        s0_ready = ~fifo_full;
        fifo_we  = s0_valid & ~fifo_full;
        fifo_di  = {s0_last, s0_data};
        if (s0_valid && !fifo_full && s0_last) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b1;
        end
      end
      XFER1: begin
        s1_ready = ~fifo_full;
        fifo_we  = s1_valid & ~fifo_full;
        fifo_di  = {s1_last, s1_data};
        if (s1_valid && !fifo_full && s1_last) begin
          state_d  = IDLE;
          rr_ptr_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign last0_acc = (state_q == XFER0) & s0_valid & ~fifo_full & s0_last;
  assign last1_acc = (state_q == XFER1) & s1_valid & ~fifo_full & s1_last;

  assign grant = {state_q == XFER1, state_q == XFER0};
  assign busy  = (state_q != IDLE);

`ifdef RAW_FIFO_ARB_STATS_EN
  // Completed-frame counters; they wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt0 <= '0;
      frm_cnt1 <= '0;
    end else begin
      if (last0_acc) frm_cnt0 <= frm_cnt0 + 1'b1;
      if (last1_acc) frm_cnt1 <= frm_cnt1 + 1'b1;
    end
  end
`else
  // Without the stats build the last-beat strobes have no consumer.
  logic unused_last_acc;
  assign unused_last_acc = last0_acc ^ last1_acc;
`endif

endmodule

// File: tb/tb_raw_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_raw_fifo_wr_arbiter
//
// Directed self-checking bench for raw_fifo_wr_arbiter. Inputs change 1 time
// unit after the rising edge; outputs are compared 1 unit later, well away
// from the next edge. Bytes written to the FIFO port are also captured so a
// stalled frame can be compared byte-for-byte against what the source sent.
// ---------------------------------------------------------------------------
module tb_raw_fifo_wr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s0_data = '0;
  logic       s0_last = 1'b0;
  logic       s0_valid = 1'b0;
  logic       s0_ready;
  logic [7:0] s1_data = '0;
  logic       s1_last = 1'b0;
  logic       s1_valid = 1'b0;
  logic       s1_ready;
  logic [8:0] fifo_di;
  logic       fifo_we;
  logic       fifo_full = 1'b0;
  logic       fifo_afull = 1'b0;
  logic [1:0] grant;
  logic       busy;
`ifdef RAW_FIFO_ARB_STATS_EN
  logic [3:0] frm_cnt0;
  logic [3:0] frm_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  logic [8:0] cap[$];

  raw_fifo_wr_arbiter #(.CNT_W(4), .FIRST_PRIO(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s0_data   (s0_data),
    .s0_last   (s0_last),
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s1_data   (s1_data),
    .s1_last   (s1_last),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .fifo_di   (fifo_di),
    .fifo_we   (fifo_we),
    .fifo_full (fifo_full),
    .fifo_afull(fifo_afull),
    .grant     (grant),
    .busy      (busy)
`ifdef RAW_FIFO_ARB_STATS_EN
    ,
    .frm_cnt0  (frm_cnt0),
    .frm_cnt1  (frm_cnt1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fifo_we) cap.push_back(fifo_di);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic l0, input logic [7:0] d0,
                     input logic v1, input logic l1, input logic [7:0] d1,
                     input logic full, input logic afull);
    s0_valid = v0; s0_last = l0; s0_data = d0;
    s1_valid = v1; s1_last = l1; s1_data = d1;
    fifo_full = full; fifo_afull = afull;
    #1;
  endtask

  // Compare the whole write-port view; fifo_di only matters while writing.
  task automatic expect_out(input string tag, input logic [1:0] g, input logic r0,
                            input logic r1, input logic we, input logic [8:0] di);
    check({tag, ".grant"}, grant, g);
    check({tag, ".busy"}, busy, g != 2'b00);
    check({tag, ".s0_ready"}, s0_ready, r0);
    check({tag, ".s1_ready"}, s1_ready, r1);
    check({tag, ".we"}, fifo_we, we);
    if (we) check({tag, ".di"}, fifo_di, di);
  endtask

  logic [8:0] exp_frame [5];

  initial begin
    // Reset state
    #2;
    expect_out("rst", 2'b00, 0, 0, 0, 9'h000);
    check("rst.di", fifo_di, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single source, three-byte frame
    drv(1, 0, 8'hA1, 0, 0, 8'h00, 0, 0);
    expect_out("t1_c0", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'hA1, 0, 0, 8'h00, 0, 0);
    expect_out("t1_c1", 2'b01, 1, 0, 1, 9'h0A1);
    nxt(); drv(1, 0, 8'hA2, 0, 0, 8'h00, 0, 0);
    expect_out("t1_c2", 2'b01, 1, 0, 1, 9'h0A2);
    nxt(); drv(1, 1, 8'hA3, 0, 0, 8'h00, 0, 0);
    expect_out("t1_c3", 2'b01, 1, 0, 1, 9'h1A3);
    nxt(); drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_out("t1_c4", 2'b00, 0, 0, 0, 9'h000);

    // 2: both sources contend from reset release, alternating 2-byte frames
    nxt();
    @(negedge clk); rst_n = 1'b0;
    drv(1, 0, 8'h10, 1, 0, 8'h20, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drv(1, 0, 8'h10, 1, 0, 8'h20, 0, 0);
    expect_out("t2_c0", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'h10, 1, 0, 8'h20, 0, 0);
    expect_out("t2_c1", 2'b01, 1, 0, 1, 9'h010);
    nxt(); drv(1, 1, 8'h11, 1, 0, 8'h20, 0, 0);
    expect_out("t2_c2", 2'b01, 1, 0, 1, 9'h111);
    nxt(); drv(1, 0, 8'h30, 1, 0, 8'h20, 0, 0);
    expect_out("t2_c3", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'h30, 1, 0, 8'h20, 0, 0);
    expect_out("t2_c4", 2'b10, 0, 1, 1, 9'h020);
    nxt(); drv(1, 0, 8'h30, 1, 1, 8'h21, 0, 0);
    expect_out("t2_c5", 2'b10, 0, 1, 1, 9'h121);
    nxt(); drv(1, 0, 8'h30, 1, 0, 8'h40, 0, 0);
    expect_out("t2_c6", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'h30, 1, 0, 8'h40, 0, 0);
    expect_out("t2_c7", 2'b01, 1, 0, 1, 9'h030);
    nxt(); drv(1, 1, 8'h31, 1, 0, 8'h40, 0, 0);
    expect_out("t2_c8", 2'b01, 1, 0, 1, 9'h131);
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h40, 0, 0);
    expect_out("t2_c9", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h40, 0, 0);
    expect_out("t2_c10", 2'b10, 0, 1, 1, 9'h040);
    nxt(); drv(0, 0, 8'h00, 1, 1, 8'h41, 0, 0);
    expect_out("t2_c11", 2'b10, 0, 1, 1, 9'h141);
    nxt(); drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_out("t2_c12", 2'b00, 0, 0, 0, 9'h000);

    // 3: almost-full blocks admission; grant follows one cycle after it drops
    for (int i = 0; i < 10; i++) begin
      nxt(); drv(0, 0, 8'h00, 1, 1, 8'h55, 0, 1);
      expect_out($sformatf("t3_afull%0d", i), 2'b00, 0, 0, 0, 9'h000);
    end
    nxt(); drv(0, 0, 8'h00, 1, 1, 8'h55, 0, 0);
    expect_out("t3_drop", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(0, 0, 8'h00, 1, 1, 8'h55, 0, 0);
    expect_out("t3_grant", 2'b10, 0, 1, 1, 9'h155);
    nxt(); drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_out("t3_idle", 2'b00, 0, 0, 0, 9'h000);

    // 4: full stall, valid gap and afull mid-frame on a 5-byte frame
    exp_frame = '{9'h061, 9'h062, 9'h063, 9'h064, 9'h165};
    nxt(); cap.delete();
    drv(1, 0, 8'h61, 0, 0, 8'h00, 0, 0);
    expect_out("t4_c0", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'h61, 0, 0, 8'h00, 0, 0);
    expect_out("t4_b1", 2'b01, 1, 0, 1, 9'h061);
    nxt(); drv(1, 0, 8'h62, 0, 0, 8'h00, 0, 0);
    expect_out("t4_b2", 2'b01, 1, 0, 1, 9'h062);
    for (int i = 0; i < 3; i++) begin
      nxt(); drv(1, 0, 8'h63, 0, 0, 8'h00, 1, 0);
      expect_out($sformatf("t4_full%0d", i), 2'b01, 0, 0, 0, 9'h000);
    end
    nxt(); drv(1, 0, 8'h63, 0, 0, 8'h00, 0, 0);
    expect_out("t4_b3", 2'b01, 1, 0, 1, 9'h063);
    nxt(); drv(0, 0, 8'h64, 0, 0, 8'h00, 0, 1);
    expect_out("t4_gap", 2'b01, 1, 0, 0, 9'h000);
    nxt(); drv(1, 0, 8'h64, 0, 0, 8'h00, 0, 1);
    expect_out("t4_b4", 2'b01, 1, 0, 1, 9'h064);
    nxt(); drv(1, 1, 8'h65, 0, 0, 8'h00, 0, 1);
    expect_out("t4_b5", 2'b01, 1, 0, 1, 9'h165);
    nxt(); drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_out("t4_idle", 2'b00, 0, 0, 0, 9'h000);
    check("t4_cap_len", cap.size(), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t4_cap%0d", i), (i < cap.size()) ? cap[i] : 9'h1FF, exp_frame[i]);

    // 5: asynchronous reset mid-frame, then contested grant goes to FIRST_PRIO
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h71, 0, 0);
    expect_out("t5_c0", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h71, 0, 0);
    expect_out("t5_b1", 2'b10, 0, 1, 1, 9'h071);
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h72, 0, 0);
    expect_out("t5_b2", 2'b10, 0, 1, 1, 9'h072);
    nxt(); drv(0, 0, 8'h00, 1, 0, 8'h73, 0, 0);
    expect_out("t5_b3", 2'b10, 0, 1, 1, 9'h073);
    rst_n = 1'b0;
    #1;
    expect_out("t5_rst", 2'b00, 0, 0, 0, 9'h000);
    drv(1, 1, 8'h81, 1, 0, 8'h71, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    drv(1, 1, 8'h81, 1, 0, 8'h71, 0, 0);
    expect_out("t5_c0r", 2'b00, 0, 0, 0, 9'h000);
    nxt(); drv(1, 1, 8'h81, 1, 0, 8'h71, 0, 0);
    expect_out("t5_prio", 2'b01, 1, 0, 1, 9'h181);
    nxt(); drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    expect_out("t5_idle", 2'b00, 0, 0, 0, 9'h000);

`ifdef RAW_FIFO_ARB_STATS_EN
    // 6: counters wrap at 2^4
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("t6_rst0", frm_cnt0, 4'd0);
    check("t6_rst1", frm_cnt1, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drv(1, 1, 8'(k), 0, 0, 8'h00, 0, 0);
      nxt(); nxt();
    end
    drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("t6_cnt0a", frm_cnt0, 4'd5);
    for (int k = 0; k < 18; k++) begin
      drv(0, 0, 8'h00, 1, 1, 8'(k), 0, 0);
      nxt(); nxt();
    end
    drv(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    check("t6_cnt0b", frm_cnt0, 4'd5);
    check("t6_cnt1", frm_cnt1, 4'd2);
`endif

    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
